wb_port_arbiter: RTL and testbench



---
 rtl/wb_port_arbiter_pkg.sv | 26 ++
 rtl/wb_port_arbiter_rr_pick2.sv | 51 +++++
 rtl/wb_port_arbiter.sv | 116 +++++++++++
 tb/tb_wb_port_arbiter.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/wb_port_arbiter_pkg.sv
// Shared types and constants for the writeback port arbiter.
//   reg_addr_t : architectural register index (register 0 is never written)
//   uint32_t   : 32-bit data word
//   wb_req_t   : one writeback result (byte enables, destination, data)
//   WB_REQ_NUM : number of writeback requesters in the core (ALU1, ALU2, LSU, MDU)
package wb_port_arbiter_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int WB_REQ_NUM = 4;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [31:0]           uint32_t;

    typedef struct packed {
        logic [3:0] we;
        reg_addr_t  waddr;
        uint32_t    wdata;
    } wb_req_t;

    // A result with no byte enables or aimed at register 0 writes nothing,
    // so it can be retired without consuming a write port.
    function automatic logic is_null_req(input logic [3:0] we, input reg_addr_t waddr);
        return (we == 4'b0000) || (waddr == '0);
    endfunction

endpackage

// File: rtl/wb_port_arbiter_rr_pick2.sv
// Rotating two-winner picker.
//   cand      : candidate mask (real requests)
//   rr_ptr    : index where the scan starts
//   same_addr : same_addr[i][j] = 1 when requesters i and j target the same register
//   grant1/2  : one-hot winners, grant1 is the first candidate found from rr_ptr
//   valid1/2  : winner present
//   idx1/2    : binary index of each winner
module wb_port_arbiter_rr_pick2 #(
    parameter int N     = 4,
    parameter int PTR_W = 2
) (
    input  logic [N-1:0]          cand,
    input  logic [PTR_W-1:0]      rr_ptr,
    input  logic [N-1:0][N-1:0]   same_addr,
    output logic [N-1:0]          grant1,
    output logic [N-1:0]          grant2,
    output logic                  valid1,
    output logic                  valid2,
    output logic [PTR_W-1:0]      idx1,
    output logic [PTR_W-1:0]      idx2
);

    always_comb begin
        int idx;
        idx    = 0;
        grant1 = '0;
        grant2 = '0;
        valid1 = 1'b0;
        valid2 = 1'b0;
        idx1   = '0;
        idx2   = '0;
        for (int k = 0; k < N; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= N) idx = idx - N;
            if (cand[idx]) begin
                if (!valid1) begin
                    valid1      = 1'b1;
                    idx1        = PTR_W'(idx);
                    grant1[idx] = 1'b1;
                end else if (!valid2 && !same_addr[idx1][idx]) begin
                    // A second write to slot1's register waits, even when the
                    // byte enables would not overlap.
                    valid2      = 1'b1;
                    idx2        = PTR_W'(idx);
                    grant2[idx] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Writeback port arbiter: shares the two register-file write ports between
// N_REQ valid/ready requesters, granting up to two results per cycle by
// rotating round-robin and registering them onto the write ports.
//   clk, rst                : clock, asynchronous active-high reset
//   req_valid/we/waddr/wdata: per-requester results
//   req_ready               : result accepted this cycle
//   inst1_*, inst2_*        : registered write ports (inst1 used first)
//   stall_cnt               : cycles in which a real request was left waiting
//
// Handshake: a result transfers in any cycle where req_valid[i] && req_ready[i].
// req_ready is a function of req_valid/we/waddr and rr_ptr only; a requester
// keeps all fields stable while valid && !ready.
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int N_REQ = WB_REQ_NUM,
    parameter int CNT_W = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_REQ-1:0]            req_valid,
    input  logic [N_REQ-1:0][3:0]       req_we,
    input  reg_addr_t [N_REQ-1:0]       req_waddr,
    input  logic [N_REQ-1:0][31:0]      req_wdata,
    output logic [N_REQ-1:0]            req_ready,
    output logic [3:0]                  inst1_we,
    output reg_addr_t                   inst1_waddr,
    output logic [31:0]                 inst1_wdata,
    output logic [3:0]                  inst2_we,
    output reg_addr_t                   inst2_waddr,
    output logic [31:0]                 inst2_wdata,
    output logic [CNT_W-1:0]            stall_cnt
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [PTR_W-1:0]             rr_ptr;
    logic [N_REQ-1:0]             null_req;
    logic [N_REQ-1:0]             real_req;
    logic [N_REQ-1:0][N_REQ-1:0]  same_addr;
    logic [N_REQ-1:0]             grant1, grant2;
    logic                         valid1, valid2;
    logic [PTR_W-1:0]             idx1, idx2;
    wb_req_t                      slot1, slot2;
    logic                         stall;

    always_comb begin
        null_req  = '0;
        real_req  = '0;
        same_addr = '0;
        for (int i = 0; i < N_REQ; i++) begin
            null_req[i] = req_valid[i] && is_null_req(req_we[i], req_waddr[i]);
            real_req[i] = req_valid[i] && !is_null_req(req_we[i], req_waddr[i]);
            for (int j = 0; j < N_REQ; j++) begin
                same_addr[i][j] = (req_waddr[i] == req_waddr[j]);
            end
        end
    end

    wb_port_arbiter_rr_pick2 #(
        .N     (N_REQ),
        .PTR_W (PTR_W)
    ) u_pick (
        .cand      (real_req),
        .rr_ptr    (rr_ptr),
        .same_addr (same_addr),
        .grant1    (grant1),
        .grant2    (grant2),
        .valid1    (valid1),
        .valid2    (valid2),
        .idx1      (idx1),
        .idx2      (idx2)
    );

    // Null requests retire immediately; they never reach a write port.
    assign req_ready = grant1 | grant2 | null_req;
    assign stall     = |(real_req & ~(grant1 | grant2));

    always_comb begin
        slot1 = '{we: req_we[idx1], waddr: req_waddr[idx1], wdata: req_wdata[idx1]};
        slot2 = '{we: req_we[idx2], waddr: req_waddr[idx2], wdata: req_wdata[idx2]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inst1_we    <= 4'b0000;
            inst1_waddr <= '0;
            inst1_wdata <= '0;
            inst2_we    <= 4'b0000;
            inst2_waddr <= '0;
            inst2_wdata <= '0;
            rr_ptr      <= '0;
            stall_cnt   <= '0;
        end else begin
            // Empty slots only drop the byte enables; address/data hold.
            inst1_we <= valid1 ? slot1.we : 4'b0000;
            inst2_we <= valid2 ? slot2.we : 4'b0000;
            if (valid1) begin
                inst1_waddr <= slot1.waddr;
                inst1_wdata <= slot1.wdata;
            end
            if (valid2) begin
                inst2_waddr <= slot2.waddr;
                inst2_wdata <= slot2.wdata;
            end
            // Resume the scan just past the last winner.
            if (valid2) begin
                rr_ptr <= (idx2 == PTR_W'(N_REQ - 1)) ? '0 : idx2 + 1'b1;
            end else if (valid1) begin
                rr_ptr <= (idx1 == PTR_W'(N_REQ - 1)) ? '0 : idx1 + 1'b1;
            end
            if (stall) stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
module tb_wb_port_arbiter;
    import wb_port_arbiter_pkg::*;

    localparam int N = 4;

    logic                 clk;
    logic                 rst;
    logic [N-1:0]         req_valid;
    logic [N-1:0][3:0]    req_we;
    reg_addr_t [N-1:0]    req_waddr;
    logic [N-1:0][31:0]   req_wdata;
    logic [N-1:0]         req_ready;
    logic [3:0]           inst1_we, inst2_we;
    reg_addr_t            inst1_waddr, inst2_waddr;
    logic [31:0]          inst1_wdata, inst2_wdata;
    logic [31:0]          stall_cnt;

    int tests_run;
    int tests_failed;
    int grant_cnt [N];

    wb_port_arbiter #(.N_REQ(N), .CNT_W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_we      (req_we),
        .req_waddr   (req_waddr),
        .req_wdata   (req_wdata),
        .req_ready   (req_ready),
        .inst1_we    (inst1_we),
        .inst1_waddr (inst1_waddr),
        .inst1_wdata (inst1_wdata),
        .inst2_we    (inst2_we),
        .inst2_waddr (inst2_waddr),
        .inst2_wdata (inst2_wdata),
        .stall_cnt   (stall_cnt)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; outputs are sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [3:0] we, input reg_addr_t a, input logic [31:0] d);
        req_we[i]    = we;
        req_waddr[i] = a;
        req_wdata[i] = d;
    endtask

    // Mid-cycle asynchronous reset pulse; outputs must clear before any edge.
    task automatic pulse_reset(input string tag);
        req_valid = '0;
        #2;
        rst = 1'b1;
        #1;
        chk({tag, "_async_i1we"}, 64'(inst1_we), 64'h0);
        chk({tag, "_async_i2we"}, 64'(inst2_we), 64'h0);
        chk({tag, "_async_stall"}, 64'(stall_cnt), 64'h0);
        step();
        rst = 1'b0;
    endtask

    task automatic chk_port1(input string tag, input logic [3:0] we, input reg_addr_t a, input logic [31:0] d);
        chk({tag, "_i1we"}, 64'(inst1_we), 64'(we));
        chk({tag, "_i1waddr"}, 64'(inst1_waddr), 64'(a));
        chk({tag, "_i1wdata"}, 64'(inst1_wdata), 64'(d));
    endtask

    task automatic chk_port2(input string tag, input logic [3:0] we, input reg_addr_t a, input logic [31:0] d);
        chk({tag, "_i2we"}, 64'(inst2_we), 64'(we));
        chk({tag, "_i2waddr"}, 64'(inst2_waddr), 64'(a));
        chk({tag, "_i2wdata"}, 64'(inst2_wdata), 64'(d));
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        for (int i = 0; i < N; i++) grant_cnt[i] = 0;

        // Reset held with every requester valid.
        rst       = 1'b1;
        req_valid = 4'b1111;
        for (int i = 0; i < N; i++) set_req(i, 4'hF, reg_addr_t'(i + 1), 32'hCAFE_0000 + 32'(i));
        step();
        step();
        chk_port1("reset", 4'h0, 5'd0, 32'h0);
        chk_port2("reset", 4'h0, 5'd0, 32'h0);
        chk("reset_stall", 64'(stall_cnt), 64'h0);
        req_valid = '0;
        rst       = 1'b0;
        step();

        // Single request on ALU1.
        set_req(0, 4'hF, 5'd5, 32'hDEAD_BEEF);
        req_valid = 4'b0001;
        #1;
        chk("single_ready", 64'(req_ready), 64'h1);
        step();
        req_valid = '0;
        chk_port1("single", 4'hF, 5'd5, 32'hDEAD_BEEF);
        chk("single_i2we", 64'(inst2_we), 64'h0);
        chk("single_stall", 64'(stall_cnt), 64'h0);
        step();
        chk("idle_i1we", 64'(inst1_we), 64'h0);

        // Four real requests, distinct destinations, rr_ptr back at 0.
        pulse_reset("rst1");
        for (int i = 0; i < N; i++) set_req(i, 4'hF, reg_addr_t'(i + 1), 32'h1111_0000 + 32'(i));
        req_valid = 4'b1111;
        #1;
        chk("four_c0_ready", 64'(req_ready), 64'h3);
        step();
        req_valid = 4'b1100;
        chk_port1("four_c0", 4'hF, 5'd1, 32'h1111_0000);
        chk_port2("four_c0", 4'hF, 5'd2, 32'h1111_0001);
        chk("four_c0_stall", 64'(stall_cnt), 64'h1);
        #1;
        chk("four_c1_ready", 64'(req_ready), 64'hC);
        step();
        req_valid = '0;
        chk_port1("four_c1", 4'hF, 5'd3, 32'h1111_0002);
        chk_port2("four_c1", 4'hF, 5'd4, 32'h1111_0003);
        chk("four_c1_stall", 64'(stall_cnt), 64'h1);
        step();
        chk("four_idle_i1we", 64'(inst1_we), 64'h0);
        chk("four_idle_i2we", 64'(inst2_we), 64'h0);

        // Same-destination conflict: 0 and 2 both write r7.
        pulse_reset("rst2");
        set_req(0, 4'h3, 5'd7, 32'h0000_AAAA);
        set_req(2, 4'hC, 5'd7, 32'hBBBB_0000);
        req_valid = 4'b0101;
        #1;
        chk("conf_c0_ready", 64'(req_ready), 64'h1);
        step();
        req_valid = 4'b0100;
        chk_port1("conf_c0", 4'h3, 5'd7, 32'h0000_AAAA);
        chk("conf_c0_i2we", 64'(inst2_we), 64'h0);
        chk("conf_c0_stall", 64'(stall_cnt), 64'h1);
        #1;
        chk("conf_c1_ready", 64'(req_ready), 64'h4);
        step();
        req_valid = '0;
        chk_port1("conf_c1", 4'hC, 5'd7, 32'hBBBB_0000);
        chk("conf_c1_i2we", 64'(inst2_we), 64'h0);
        chk("conf_c1_stall", 64'(stall_cnt), 64'h1);

        // Null requests (waddr=0, and we=0) beside two real ones.
        pulse_reset("rst3");
        set_req(0, 4'hF, 5'd10, 32'h0A0A_0A0A);
        set_req(1, 4'hF, 5'd0,  32'h1111_1111);
        set_req(2, 4'h5, 5'd12, 32'h0C0C_0C0C);
        set_req(3, 4'h0, 5'd9,  32'h3333_3333);
        req_valid = 4'b0111;
        #1;
        chk("null_ready3", 64'(req_ready), 64'h7);
        req_valid = 4'b1111;
        #1;
        chk("null_ready4", 64'(req_ready), 64'hF);
        step();
        req_valid = '0;
        chk_port1("null", 4'hF, 5'd10, 32'h0A0A_0A0A);
        chk_port2("null", 4'h5, 5'd12, 32'h0C0C_0C0C);
        chk("null_stall", 64'(stall_cnt), 64'h0);

        // Fairness: all four held valid for 8 cycles.
        pulse_reset("rst4");
        for (int i = 0; i < N; i++) set_req(i, 4'hF, reg_addr_t'(i + 20), 32'h5000_0000 + 32'(i));
        req_valid = 4'b1111;
        for (int c = 0; c < 8; c++) begin
            #1;
            for (int i = 0; i < N; i++) if (req_ready[i]) grant_cnt[i]++;
            step();
        end
        req_valid = '0;
        for (int i = 0; i < N; i++) chk($sformatf("fair_cnt%0d", i), 64'(grant_cnt[i]), 64'd4);
        chk("fair_stall", 64'(stall_cnt), 64'd8);
        chk_port1("fair_last", 4'hF, 5'd22, 32'h5000_0002);
        chk_port2("fair_last", 4'hF, 5'd23, 32'h5000_0003);

        // Async reset while the ports are busy.
        pulse_reset("rst5");
        chk_port1("post_rst", 4'h0, 5'd0, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
